// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control block.
// Holds the opcode constants, the control-word bit positions and width,
// the decoded control words for each instruction class, and the
// per-cycle pipeline action type.
package pipeline_pkg;

    localparam int CTRL_W = 12;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Control-word bit positions, MSB first
    localparam int BIT_UNCOND    = 11;
    localparam int BIT_ADDRSRC   = 10;
    localparam int BIT_ALUSRCA   = 9;
    localparam int BIT_ALUSRCB_H = 8;
    localparam int BIT_ALUSRCB_L = 7;
    localparam int BIT_MEMTOREG  = 6;
    localparam int BIT_REGWRITE  = 5;
    localparam int BIT_MEMREAD   = 4;
    localparam int BIT_MEMWRITE  = 3;
    localparam int BIT_BRANCH    = 2;
    localparam int BIT_ALUOP_H   = 1;
    localparam int BIT_ALUOP_L   = 0;

    // Decoded control words
    localparam logic [CTRL_W-1:0] CW_NOP    = 12'h000;
    localparam logic [CTRL_W-1:0] CW_LOAD   = 12'h0F0;
    localparam logic [CTRL_W-1:0] CW_STORE  = 12'h088;
    localparam logic [CTRL_W-1:0] CW_RTYPE  = 12'h022;
    localparam logic [CTRL_W-1:0] CW_ITYPE  = 12'h0A3;
    localparam logic [CTRL_W-1:0] CW_BRANCH = 12'h005;
    localparam logic [CTRL_W-1:0] CW_JALR   = 12'hF24;
    localparam logic [CTRL_W-1:0] CW_JAL    = 12'hB24;

    // What the stage registers do on the next edge
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_STALL,
        ACT_FLUSH,
        ACT_FREEZE
    } pipe_act_t;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// hazard_detect: combinational hazard logic for pipeline_control.
// Detects load-use hazards against the instruction in ID and, depending on
// the build, either RAW hazards against EX/MEM (no forwarding) or the
// forwarding selects for the instruction in EX.
// Build macro: PIPELINE_CONTROL_FORWARD_EN
// Ports:
//   ex_memread, ex_regwrite, mem_regwrite, wb_regwrite : control bits per stage
//   rd_ex, rd_mem, rd_wb : destination registers per stage
//   rs1_id, rs2_id       : sources of the instruction in ID
//   rs1_ex, rs2_ex       : sources of the instruction in EX (forwarding build)
//   fwd_a, fwd_b         : 00 regfile, 01 MEM, 10 WB (forwarding build)
//   stall                : hold PC and IF/ID, bubble into EX
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            ex_memread,
`ifndef PIPELINE_CONTROL_FORWARD_EN
    input  logic            ex_regwrite,
`endif
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] rd_ex,
    input  logic [RA_W-1:0] rd_mem,
    input  logic [RA_W-1:0] rs1_id,
    input  logic [RA_W-1:0] rs2_id,
`ifdef PIPELINE_CONTROL_FORWARD_EN
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] rd_wb,
    input  logic [RA_W-1:0] rs1_ex,
    input  logic [RA_W-1:0] rs2_ex,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
`endif
    output logic            stall
);

    logic ex_hit;
    logic load_use;

    // x0 is hard-wired, so a zero destination never creates a dependency
    assign ex_hit   = (rd_ex != '0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    assign load_use = ex_memread && ex_hit;

`ifdef PIPELINE_CONTROL_FORWARD_EN
    logic mem_fa, mem_fb, wb_fa, wb_fb;

    assign mem_fa = mem_regwrite && (rd_mem != '0) && (rd_mem == rs1_ex);
    assign mem_fb = mem_regwrite && (rd_mem != '0) && (rd_mem == rs2_ex);
    assign wb_fa  = wb_regwrite  && (rd_wb  != '0) && (rd_wb  == rs1_ex);
    assign wb_fb  = wb_regwrite  && (rd_wb  != '0) && (rd_wb  == rs2_ex);

    // The younger result in MEM wins over WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_fa)     fwd_a = 2'b01;
        else if (wb_fa) fwd_a = 2'b10;
        if (mem_fb)     fwd_b = 2'b01;
        else if (wb_fb) fwd_b = 2'b10;
    end

    assign stall = load_use;
`else
    logic mem_hit;

    // Without bypass paths every pending write in EX or MEM must drain first;
    // WB is assumed to write the register file before ID reads it.
    assign mem_hit = (rd_mem != '0) && ((rd_mem == rs1_id) || (rd_mem == rs2_id));
    assign stall   = load_use || (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
`endif

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: decode and stage-register control for a 5-stage pipeline.
// Decodes the opcode in ID into a 12-bit control word, carries control words
// and destination registers through EX/MEM/WB, and resolves memory freezes,
// branch flushes and data-hazard stalls (freeze > flush > stall > advance).
// Build macro: PIPELINE_CONTROL_FORWARD_EN adds fwd_a/fwd_b and limits
// stalls to load-use hazards.
// Ports:
//   clk, reset (async, active-high)
//   opcode_id, rs1_id, rs2_id, rd_id : instruction in ID
//   branch_taken_ex                  : branch/jump in EX resolved taken
//   ctrl_ex/mem/wb, rd_ex/mem/wb     : registered per-stage control and rd
//   pc_we, ifid_we, ifid_flush       : front-end controls
//   illegal_id                       : opcode_id not in the decode table
//   fwd_a, fwd_b                     : forwarding selects (forwarding build)
module pipeline_control
    import pipeline_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int RA_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        opcode_id,
    input  logic [RA_W-1:0]   rs1_id,
    input  logic [RA_W-1:0]   rs2_id,
    input  logic [RA_W-1:0]   rd_id,
    input  logic              branch_taken_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [CTRL_W-1:0] ctrl_mem,
    output logic [CTRL_W-1:0] ctrl_wb,
    output logic [RA_W-1:0]   rd_ex,
    output logic [RA_W-1:0]   rd_mem,
    output logic [RA_W-1:0]   rd_wb,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
`ifdef PIPELINE_CONTROL_FORWARD_EN
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`endif
    output logic              illegal_id
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [CTRL_W-1:0] ctrl_dec;
    logic [3:0]        mem_cnt;
    logic              hz_stall;
    logic              mem_enter;
    pipe_act_t         act;

`ifdef PIPELINE_CONTROL_FORWARD_EN
    logic [RA_W-1:0] rs1_ex, rs2_ex;
`endif

    // Decode; unknown opcodes become a no-op and raise illegal_id
    always_comb begin
        ctrl_dec   = CW_NOP;
        illegal_id = 1'b0;
        case (opcode_id)
            OP_NOP:    ctrl_dec = CW_NOP;
            OP_LOAD:   ctrl_dec = CW_LOAD;
            OP_STORE:  ctrl_dec = CW_STORE;
            OP_RTYPE:  ctrl_dec = CW_RTYPE;
            OP_ITYPE:  ctrl_dec = CW_ITYPE;
            OP_BRANCH: ctrl_dec = CW_BRANCH;
            OP_JALR:   ctrl_dec = CW_JALR;
            OP_JAL:    ctrl_dec = CW_JAL;
            default: begin
                ctrl_dec   = CW_NOP;
                illegal_id = 1'b1;
            end
        endcase
    end

    hazard_detect #(.RA_W(RA_W)) u_hazard (
        .ex_memread   (ctrl_ex[BIT_MEMREAD]),
`ifndef PIPELINE_CONTROL_FORWARD_EN
        .ex_regwrite  (ctrl_ex[BIT_REGWRITE]),
`endif
        .mem_regwrite (ctrl_mem[BIT_REGWRITE]),
        .rd_ex        (rd_ex),
        .rd_mem       (rd_mem),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
`ifdef PIPELINE_CONTROL_FORWARD_EN
        .wb_regwrite  (ctrl_wb[BIT_REGWRITE]),
        .rd_wb        (rd_wb),
        .rs1_ex       (rs1_ex),
        .rs2_ex       (rs2_ex),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
`endif
        .stall        (hz_stall)
    );

    // A memory op is about to move from EX into MEM
    assign mem_enter = ctrl_ex[BIT_MEMREAD] || ctrl_ex[BIT_MEMWRITE];

    // Action priority: freeze > flush > stall > advance
    always_comb begin
        act = ACT_ADVANCE;
        if (mem_cnt != 4'd0)
            act = ACT_FREEZE;
        else if (branch_taken_ex && ctrl_ex[BIT_BRANCH])
            act = ACT_FLUSH;
        else if (hz_stall)
            act = ACT_STALL;
    end

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        ifid_flush = 1'b0;
        if (!reset) begin
            case (act)
                ACT_FREEZE, ACT_STALL: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end
                ACT_FLUSH: ifid_flush = 1'b1;
                default: ;
            endcase
        end
    end

    // ID -> EX -> MEM -> WB stage registers and memory-latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_ex  <= '0;
            ctrl_mem <= '0;
            ctrl_wb  <= '0;
            rd_ex    <= '0;
            rd_mem   <= '0;
            rd_wb    <= '0;
            mem_cnt  <= '0;
`ifdef PIPELINE_CONTROL_FORWARD_EN
            rs1_ex   <= '0;
            rs2_ex   <= '0;
`endif
        end else if (act == ACT_FREEZE) begin
            mem_cnt <= mem_cnt - 4'd1;
        end else begin
            if (act == ACT_ADVANCE) begin
                ctrl_ex <= ctrl_dec;
                rd_ex   <= rd_id;
`ifdef PIPELINE_CONTROL_FORWARD_EN
                rs1_ex  <= rs1_id;
                rs2_ex  <= rs2_id;
`endif
            end else begin
                ctrl_ex <= CW_NOP;
                rd_ex   <= '0;
`ifdef PIPELINE_CONTROL_FORWARD_EN
                rs1_ex  <= '0;
                rs2_ex  <= '0;
`endif
            end
            ctrl_mem <= ctrl_ex;
            rd_mem   <= rd_ex;
            ctrl_wb  <= ctrl_mem;
            rd_wb    <= rd_mem;
            // With single-cycle memory the counter never leaves zero
            if ((MEM_LAT > 1) && mem_enter)
                mem_cnt <= CNT_LOAD;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control. Two instances share the ID-side
// stimulus: d1 (MEM_LAT=1) and d3 (MEM_LAT=3). Expected values are queued
// as each step is driven and checked when the DUT responds: phase 0 items
// are combinational outputs checked before the edge, phase 1 items are
// registered outputs checked just after the edge.
module tb_pipeline_control;

    localparam logic [6:0] O_NOP = 7'b0000000;
    localparam logic [6:0] O_LW  = 7'b0000011;
    localparam logic [6:0] O_SW  = 7'b0100011;
    localparam logic [6:0] O_R   = 7'b0110011;
    localparam logic [6:0] O_BEQ = 7'b1100011;
    localparam logic [6:0] O_BAD = 7'b1111111;

    localparam int S_CEX = 0, S_CMEM = 1, S_CWB = 2, S_REX = 3, S_RMEM = 4, S_RWB = 5;
    localparam int S_PCWE = 6, S_IFWE = 7, S_FLUSH = 8, S_ILL = 9, S_FA = 10, S_FB = 11;
    localparam int D3 = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode_id = '0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic       branch_taken_ex = 1'b0;

    logic [11:0] d1_ctrl_ex, d1_ctrl_mem, d1_ctrl_wb, d3_ctrl_ex, d3_ctrl_mem, d3_ctrl_wb;
    logic [4:0]  d1_rd_ex, d1_rd_mem, d1_rd_wb, d3_rd_ex, d3_rd_mem, d3_rd_wb;
    logic        d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_illegal_id;
    logic        d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_illegal_id;
    logic [1:0]  d1_fwd_a, d1_fwd_b, d3_fwd_a, d3_fwd_b;

`ifndef PIPELINE_CONTROL_FORWARD_EN
    assign d1_fwd_a = 2'b00;
    assign d1_fwd_b = 2'b00;
    assign d3_fwd_a = 2'b00;
    assign d3_fwd_b = 2'b00;
`endif

    pipeline_control #(.MEM_LAT(1), .RA_W(5)) u_d1 (
        .clk(clk), .reset(reset), .opcode_id(opcode_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .branch_taken_ex(branch_taken_ex),
        .ctrl_ex(d1_ctrl_ex), .ctrl_mem(d1_ctrl_mem), .ctrl_wb(d1_ctrl_wb),
        .rd_ex(d1_rd_ex), .rd_mem(d1_rd_mem), .rd_wb(d1_rd_wb),
        .pc_we(d1_pc_we), .ifid_we(d1_ifid_we), .ifid_flush(d1_ifid_flush),
`ifdef PIPELINE_CONTROL_FORWARD_EN
        .fwd_a(d1_fwd_a), .fwd_b(d1_fwd_b),
`endif
        .illegal_id(d1_illegal_id)
    );

    pipeline_control #(.MEM_LAT(3), .RA_W(5)) u_d3 (
        .clk(clk), .reset(reset), .opcode_id(opcode_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .branch_taken_ex(branch_taken_ex),
        .ctrl_ex(d3_ctrl_ex), .ctrl_mem(d3_ctrl_mem), .ctrl_wb(d3_ctrl_wb),
        .rd_ex(d3_rd_ex), .rd_mem(d3_rd_mem), .rd_wb(d3_rd_wb),
        .pc_we(d3_pc_we), .ifid_we(d3_ifid_we), .ifid_flush(d3_ifid_flush),
`ifdef PIPELINE_CONTROL_FORWARD_EN
        .fwd_a(d3_fwd_a), .fwd_b(d3_fwd_b),
`endif
        .illegal_id(d3_illegal_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          phase;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] obs(input int sel);
        logic [11:0] cex, cmem, cwb;
        logic [4:0]  rex, rmem, rwb;
        logic [3:0]  f;
        logic [1:0]  fa, fb;
        if (sel >= D3) begin
            cex = d3_ctrl_ex; cmem = d3_ctrl_mem; cwb = d3_ctrl_wb;
            rex = d3_rd_ex; rmem = d3_rd_mem; rwb = d3_rd_wb;
            f = {d3_pc_we, d3_ifid_we, d3_ifid_flush, d3_illegal_id};
            fa = d3_fwd_a; fb = d3_fwd_b;
        end else begin
            cex = d1_ctrl_ex; cmem = d1_ctrl_mem; cwb = d1_ctrl_wb;
            rex = d1_rd_ex; rmem = d1_rd_mem; rwb = d1_rd_wb;
            f = {d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_illegal_id};
            fa = d1_fwd_a; fb = d1_fwd_b;
        end
        case (sel % D3)
            S_CEX:   return 32'(cex);
            S_CMEM:  return 32'(cmem);
            S_CWB:   return 32'(cwb);
            S_REX:   return 32'(rex);
            S_RMEM:  return 32'(rmem);
            S_RWB:   return 32'(rwb);
            S_PCWE:  return 32'(f[3]);
            S_IFWE:  return 32'(f[2]);
            S_FLUSH: return 32'(f[1]);
            S_ILL:   return 32'(f[0]);
            S_FA:    return 32'(fa);
            S_FB:    return 32'(fb);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input string tag, input int ph, input int sel, input int v);
        item_t it;
        it.tag = tag; it.phase = ph; it.sel = sel; it.exp = 32'(v);
        sb.push_back(it);
    endtask

    task automatic now_(input string tag, input int sel, input int v);
        push(tag, 0, sel, v);
    endtask

    task automatic nxt(input string tag, input int sel, input int v);
        push(tag, 1, sel, v);
    endtask

    task automatic drain(input int ph);
        item_t       it;
        logic [31:0] o;
        while (sb.size() > 0 && sb[0].phase == ph) begin
            it = sb.pop_front();
            o  = obs(it.sel);
            total++;
            assert (o === it.exp) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", it.tag, o, it.exp);
            end
        end
    endtask

    task automatic step(input logic [6:0] op, input int a, input int b, input int d, input logic t);
        opcode_id = op;
        rs1_id = 5'(a); rs2_id = 5'(b); rd_id = 5'(d);
        branch_taken_ex = t;
    endtask

    task automatic settle();
        #1;
        drain(0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain(1);
    endtask

    task automatic do_reset();
        step(O_NOP, 0, 0, 0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge
        #1 reset = 1'b1;
        now_("rst_cex", S_CEX, 'h000);
        now_("rst_cmem", S_CMEM, 'h000);
        now_("rst_cwb", S_CWB, 'h000);
        now_("rst_rex", S_REX, 0);
        now_("rst_pcwe", S_PCWE, 1);
        now_("rst_ifwe", S_IFWE, 1);
        now_("rst_flush", S_FLUSH, 0);
        now_("rst3_cex", D3 + S_CEX, 'h000);
        now_("rst3_pcwe", D3 + S_PCWE, 1);
        settle();
        tick();
        tick();
        now_("rst_hold_cmem", S_CMEM, 'h000);
        settle();
        reset = 1'b0;

        // Decode and illegal opcode
        step(O_R, 1, 2, 3, 1'b0);
        now_("r_ill", S_ILL, 0);
        now_("r_pcwe", S_PCWE, 1);
        nxt("r_cex", S_CEX, 'h022);
        nxt("r_rex", S_REX, 3);
        settle(); tick();
        step(O_BAD, 0, 0, 0, 1'b0);
        now_("bad_ill", S_ILL, 1);
        now_("bad_pcwe", S_PCWE, 1);
        nxt("bad_cex", S_CEX, 'h000);
        nxt("bad_cmem", S_CMEM, 'h022);
        settle(); tick();
        step(O_NOP, 0, 0, 0, 1'b0);
        now_("nop_ill", S_ILL, 0);
        nxt("nop_cmem", S_CMEM, 'h000);
        nxt("nop_cwb", S_CWB, 'h022);
        settle(); tick();

        // Load into x0 never stalls
        step(O_LW, 1, 0, 0, 1'b0);
        nxt("lw0_cex", S_CEX, 'h0F0);
        settle(); tick();
        step(O_R, 0, 0, 9, 1'b0);
        now_("lw0_pcwe", S_PCWE, 1);
        nxt("lw0_next_cex", S_CEX, 'h022);
        nxt("lw0_next_rex", S_REX, 9);
        settle(); tick();

        // Load-use: lw x5 then add x6,x1,x5
        step(O_LW, 1, 0, 5, 1'b0);
        nxt("lu_lw_cex", S_CEX, 'h0F0);
        nxt("lu_lw_rex", S_REX, 5);
        settle(); tick();
        step(O_R, 1, 5, 6, 1'b0);
        now_("lu_pcwe", S_PCWE, 0);
        now_("lu_ifwe", S_IFWE, 0);
        now_("lu_flush", S_FLUSH, 0);
        nxt("lu_bubble_cex", S_CEX, 'h000);
        nxt("lu_bubble_rex", S_REX, 0);
        nxt("lu_cmem", S_CMEM, 'h0F0);
        settle(); tick();
`ifdef PIPELINE_CONTROL_FORWARD_EN
        now_("lu_release_pcwe", S_PCWE, 1);
        nxt("lu_add_cex", S_CEX, 'h022);
        nxt("lu_add_rex", S_REX, 6);
        nxt("lu_fwd_a", S_FA, 0);
        nxt("lu_fwd_b", S_FB, 2);
        settle(); tick();
`else
        now_("raw_mem_pcwe", S_PCWE, 0);
        nxt("raw_mem_cex", S_CEX, 'h000);
        nxt("raw_mem_cwb", S_CWB, 'h0F0);
        settle(); tick();
        now_("lu_release_pcwe", S_PCWE, 1);
        nxt("lu_add_cex", S_CEX, 'h022);
        nxt("lu_add_rex", S_REX, 6);
        settle(); tick();
`endif

        // Taken branch in EX beats a pending hazard on the ID instruction
        step(O_LW, 1, 0, 5, 1'b0);
        nxt("fl_lw_cex", S_CEX, 'h0F0);
        settle(); tick();
        step(O_BEQ, 1, 2, 0, 1'b0);
        now_("fl_beq_pcwe", S_PCWE, 1);
        nxt("fl_beq_cex", S_CEX, 'h005);
        settle(); tick();
        step(O_R, 5, 0, 7, 1'b1);
        now_("fl_flush", S_FLUSH, 1);
        now_("fl_pcwe", S_PCWE, 1);
        now_("fl_ifwe", S_IFWE, 1);
        nxt("fl_cex", S_CEX, 'h000);
        nxt("fl_rex", S_REX, 0);
        settle(); tick();
        step(O_NOP, 0, 0, 0, 1'b1);
        now_("fl_nonbranch_flush", S_FLUSH, 0);
        settle(); tick();

        // RAW between ALU ops: add x3 then sub x4,x3,x3
        step(O_R, 1, 2, 3, 1'b0);
        nxt("raw_add_cex", S_CEX, 'h022);
        settle(); tick();
        step(O_R, 3, 3, 4, 1'b0);
`ifdef PIPELINE_CONTROL_FORWARD_EN
        now_("raw_pcwe", S_PCWE, 1);
        nxt("raw_sub_cex", S_CEX, 'h022);
        nxt("raw_sub_rex", S_REX, 4);
        nxt("raw_fwd_a", S_FA, 1);
        nxt("raw_fwd_b", S_FB, 1);
        settle(); tick();
`else
        now_("raw_ex_pcwe", S_PCWE, 0);
        nxt("raw_ex_cex", S_CEX, 'h000);
        settle(); tick();
        now_("raw_mem_pcwe2", S_PCWE, 0);
        nxt("raw_mem_cex2", S_CEX, 'h000);
        settle(); tick();
        now_("raw_done_pcwe", S_PCWE, 1);
        nxt("raw_sub_cex", S_CEX, 'h022);
        nxt("raw_sub_rex", S_REX, 4);
        settle(); tick();
`endif

        // Memory freeze on the MEM_LAT=3 instance
        do_reset();
        step(O_SW, 1, 2, 0, 1'b0);
        nxt("fz_sw_cex", D3 + S_CEX, 'h088);
        settle(); tick();
        step(O_BEQ, 1, 2, 0, 1'b0);
        now_("fz_enter_pcwe", D3 + S_PCWE, 1);
        nxt("fz_cmem", D3 + S_CMEM, 'h088);
        nxt("fz_cex", D3 + S_CEX, 'h005);
        settle(); tick();
        step(O_NOP, 0, 0, 0, 1'b1);
        now_("fz1_pcwe", D3 + S_PCWE, 0);
        now_("fz1_ifwe", D3 + S_IFWE, 0);
        now_("fz1_flush", D3 + S_FLUSH, 0);
        nxt("fz1_cmem", D3 + S_CMEM, 'h088);
        nxt("fz1_cex", D3 + S_CEX, 'h005);
        settle(); tick();
        now_("fz2_pcwe", D3 + S_PCWE, 0);
        now_("fz2_flush", D3 + S_FLUSH, 0);
        nxt("fz2_cmem", D3 + S_CMEM, 'h088);
        settle(); tick();
        now_("fz_end_flush", D3 + S_FLUSH, 1);
        now_("fz_end_pcwe", D3 + S_PCWE, 1);
        nxt("fz_end_cex", D3 + S_CEX, 'h000);
        nxt("fz_end_cmem", D3 + S_CMEM, 'h005);
        nxt("fz_end_cwb", D3 + S_CWB, 'h088);
        settle(); tick();

        // Back-to-back loads each freeze, reset abandons the second freeze
        step(O_LW, 1, 0, 5, 1'b0);
        nxt("bb_lw1_cex", D3 + S_CEX, 'h0F0);
        settle(); tick();
        step(O_LW, 2, 0, 6, 1'b0);
        nxt("bb_lw1_cmem", D3 + S_CMEM, 'h0F0);
        nxt("bb_lw1_rmem", D3 + S_RMEM, 5);
        settle(); tick();
        step(O_NOP, 0, 0, 0, 1'b0);
        now_("bb_fz1_pcwe", D3 + S_PCWE, 0);
        nxt("bb_fz1_rex", D3 + S_REX, 6);
        settle(); tick();
        now_("bb_fz2_pcwe", D3 + S_PCWE, 0);
        nxt("bb_fz2_rmem", D3 + S_RMEM, 5);
        settle(); tick();
        now_("bb_adv_pcwe", D3 + S_PCWE, 1);
        nxt("bb_lw2_rmem", D3 + S_RMEM, 6);
        nxt("bb_lw2_cwb", D3 + S_CWB, 'h0F0);
        settle(); tick();
        now_("bb_fz3_pcwe", D3 + S_PCWE, 0);
        settle();
        reset = 1'b1;
        now_("mid_rst_cex", D3 + S_CEX, 'h000);
        now_("mid_rst_cmem", D3 + S_CMEM, 'h000);
        now_("mid_rst_cwb", D3 + S_CWB, 'h000);
        now_("mid_rst_rmem", D3 + S_RMEM, 0);
        now_("mid_rst_pcwe", D3 + S_PCWE, 1);
        now_("mid_rst_ifwe", D3 + S_IFWE, 1);
        settle();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(O_R, 1, 2, 3, 1'b0);
        now_("post_rst_pcwe", D3 + S_PCWE, 1);
        nxt("post_rst_cex", D3 + S_CEX, 'h022);
        nxt("post_rst_cmem", D3 + S_CMEM, 'h000);
        settle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter MEM_LAT, default 1, data-memory access latency in cycles (legal 1..8).
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 opcode_id  in  7  opcode of instruction in ID.
REQ-006 rs1_id, rs2_id, rd_id  in  RA_W each  source/destination registers in ID.
REQ-007 branch_taken_ex  in  1  branch/jump in EX resolved taken.
REQ-008 ctrl_ex, ctrl_mem, ctrl_wb  out  12 each  registered control word per stage.
REQ-009 rd_ex, rd_mem, rd_wb  out  RA_W each  destination register per stage.
REQ-010 pc_we, ifid_we  out  1  PC and IF/ID write enables.
REQ-011 ifid_flush  out  1  zero IF/ID this edge.
REQ-012 illegal_id  out  1  combinational flag: opcode_id not in decode table.

Function
REQ-013 Control word, MSB first: UncondBranch, AddrSrc, ALUSrcA, ALUSrcB[1:0], MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUop[1:0].
REQ-014 Decode: 0000000 nop=000; 0000011 lw=0F0; 0100011 sw=088; 0110011 R=022; 0010011 I=0A3; 1100011 branch=005; 1100111 jalr=F24; 1101111 jal=B24 (hex).
REQ-015 Unlisted opcode SHALL decode to 000 and assert illegal_id; no latch inference.
REQ-016 Each edge, unless frozen: ctrl_ex<=decoded or bubble, ctrl_mem<=ctrl_ex, ctrl_wb<=ctrl_mem; rd fields travel alongside.
REQ-017 Load-use: ctrl_ex.MemRead, rd_ex!=0, rd_ex==rs1_id or rs2_id -> pc_we=0, ifid_we=0, bubble (000, rd 0) into EX; one cycle.
REQ-018 Flush: branch_taken_ex with ctrl_ex.Branch=1 -> ifid_flush=1, bubble into EX; overrides load-use stall.
REQ-019 Memory freeze: when ctrl_mem has MemRead or MemWrite and MEM_LAT>1, down-counter loads MEM_LAT-1 on entry; while nonzero all stage registers hold, pc_we=ifid_we=0, flush suppressed until counter reaches 0.
REQ-020 Freeze has priority over flush; flush over load-use; load-use over normal advance.
REQ-021 MEM_LAT=1: counter never loads; zero freeze cycles.
REQ-022 Back-to-back memory ops each incur MEM_LAT-1 freeze cycles.

Reset
REQ-023 reset SHALL clear ctrl_*, rd_*, counter to 0 immediately; pc_we=ifid_we=1, ifid_flush=0 while asserted.
REQ-024 Reset mid-freeze or mid-stall SHALL abandon it; first post-reset cycle advances normally.

Configuration
REQ-025 Macro PIPELINE_CONTROL_FORWARD_EN defined: outputs fwd_a, fwd_b (2 bits each; 00 regfile, 01 MEM, 10 WB; MEM priority, rd 0 never matches); only load-use stalls.
REQ-026 Macro undefined: no fwd ports; any RegWrite rd (nonzero) in EX or MEM matching rs1_id/rs2_id stalls as REQ-017.

Structure
REQ-027 Package pipeline_pkg SHALL hold opcode constants, control-word field offsets, width 12, and the decode constants.
REQ-028 Sub-module hazard_detect (combinational: load-use, RAW, forwarding selects); decode and stage registers in top.

Verification
REQ-029 lw x5 then add x6,x5,x1 -> one cycle pc_we=0, ctrl_ex=000; then add enters EX.
REQ-030 beq in EX with branch_taken_ex=1 and load-use pending -> ifid_flush=1, no stall, ctrl_ex=000 next.
REQ-031 MEM_LAT=3, sw reaches MEM -> 2 frozen cycles, ctrl_mem=088 held, then advance.
REQ-032 opcode 1111111 -> illegal_id=1, ctrl_ex=000 next edge.
REQ-033 reset asserted during freeze -> outputs 0 same cycle, advance resumes after release.
REQ-034 FORWARD_EN: add x3 then sub x4,x3,x3 -> fwd_a=fwd_b=01, no stall; undefined: 2 stall cycles.
